// File: rtl/clk_div_ctrl_if.sv
// Ratio configuration port for clk_div_ctrl: valid/ready request plus error strobe.
interface clk_div_ctrl_if #(
    parameter int unsigned CW = 8
);
    logic          cfg_valid;
    logic [CW-1:0] cfg_div;
    logic          cfg_ready;
    logic          cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run/stop controller for a programmable integer clock divider.
// Produces a divided strobe (div_out) and a last-cycle-of-period tick; new
// ratios are buffered and only take effect at a period boundary.
module clk_div_ctrl #(
    parameter int unsigned CW          = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    clk_div_ctrl_if.slave   cfg,
    output logic            div_out,
    output logic            tick,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_TWO = CW'(2);
    localparam logic [CW-1:0] C_DEF = CW'(DEFAULT_DIV);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_cur_div;
    logic [CW-1:0] r_pend_div;
    logic          r_pend_vld;
    logic          r_div_out;
    logic          r_cfg_err;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cur_div_nxt;
    logic [CW-1:0] w_pend_div_nxt;
    logic          w_pend_vld_nxt;
    logic          w_div_out_nxt;
    logic [CW-1:0] w_half;
    logic          w_hs;
    logic          w_bad;
    logic          w_boundary;

    // Next-state, counter, ratio-buffer and output-pattern computation
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_div_nxt  = r_cur_div;
        w_pend_div_nxt = r_pend_div;
        w_pend_vld_nxt = r_pend_vld;

        w_hs       = cfg.cfg_valid && !r_pend_vld;
        w_bad      = w_hs && (cfg.cfg_div < C_TWO);
        w_boundary = (r_state != IDLE) && (r_cnt == (r_cur_div - C_ONE));

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // stop wins over a simultaneous start
                if (stop) begin
                    w_state_nxt = STOPPING;
                end
                w_cnt_nxt = w_boundary ? '0 : r_cnt + C_ONE;
            end
            STOPPING: begin
                // start cancels the stop and lets the period run on
                if (start) begin
                    w_state_nxt = RUN;
                end else if (w_boundary) begin
                    w_state_nxt = IDLE;
                end
                w_cnt_nxt = w_boundary ? '0 : r_cnt + C_ONE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // A ratio left pending when STOPPING reached IDLE is still committed,
        // so the buffer can never be stranded in IDLE.
        if (r_pend_vld && (w_boundary || (r_state == IDLE))) begin
            w_cur_div_nxt  = r_pend_div;
            w_pend_vld_nxt = 1'b0;
        end

        // Handshake and commit are exclusive: accept needs pend_vld=0
        if (w_hs && !w_bad) begin
            if (r_state == IDLE) begin
                w_cur_div_nxt = cfg.cfg_div;
            end else begin
                w_pend_div_nxt = cfg.cfg_div;
                w_pend_vld_nxt = 1'b1;
            end
        end

        // High phase length is ceil(N/2)
        w_half        = (w_cur_div_nxt >> 1) + CW'(w_cur_div_nxt[0]);
        w_div_out_nxt = (w_state_nxt != IDLE) && (w_cnt_nxt < w_half);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cur_div  <= C_DEF;
            r_pend_div <= '0;
            r_pend_vld <= 1'b0;
            r_div_out  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_div  <= w_cur_div_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_div_out  <= w_div_out_nxt;
            r_cfg_err  <= w_bad;
        end
    end

    assign cfg.cfg_ready = !r_pend_vld;
    assign cfg.cfg_err   = r_cfg_err;
    assign div_out       = r_div_out;
    assign tick          = w_boundary;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl. Each cycle's expected outputs
// {div_out,tick,busy,cfg_ready,cfg_err} are queued by the stimulus and
// checked by an independent monitor on the falling edge.
module tb_clk_div_ctrl;

    localparam int unsigned CW = 8;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic div_out;
    logic tick;
    logic busy;

    clk_div_ctrl_if #(.CW(CW)) cfg ();

    clk_div_ctrl #(
        .CW          (CW),
        .DEFAULT_DIV (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .cfg     (cfg),
        .div_out (div_out),
        .tick    (tick),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: pop one expectation per cycle and compare
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {div_out, tick, busy, cfg.cfg_ready, cfg.cfg_err};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b (div_out,tick,busy,cfg_ready,cfg_err) at %0t",
                             e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic step(input logic st, input logic sp, input logic v,
                        input logic [CW-1:0] d, input logic [4:0] e,
                        input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        start         = st;
        stop          = sp;
        cfg.cfg_valid = v;
        cfg.cfg_div   = d;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;

        // Reset values
        step(0, 0, 0, 0, 5'b00010, "reset0");
        step(0, 0, 0, 0, 5'b00010, "reset1");
        rst = 1'b1;

        // Test 1: default N=2
        step(1, 0, 0, 0, 5'b00010, "t1_idle");
        repeat (4) begin
            step(0, 0, 0, 0, 5'b10110, "t1_hi");
            step(0, 0, 0, 0, 5'b01110, "t1_lo_tick");
        end
        step(0, 1, 0, 0, 5'b10110, "t1_stop_req");
        step(0, 0, 0, 0, 5'b01110, "t1_stopping");
        step(0, 0, 0, 0, 5'b00010, "t1_idle_after");

        // Test 2: N=5 loaded in IDLE
        step(0, 0, 1, 5, 5'b00010, "t2_cfg");
        step(1, 0, 0, 0, 5'b00010, "t2_start");
        repeat (2) begin
            step(0, 0, 0, 0, 5'b10110, "t2_c0");
            step(0, 0, 0, 0, 5'b10110, "t2_c1");
            step(0, 0, 0, 0, 5'b10110, "t2_c2");
            step(0, 0, 0, 0, 5'b00110, "t2_c3");
            step(0, 0, 0, 0, 5'b01110, "t2_c4_tick");
        end
        step(0, 1, 0, 0, 5'b10110, "t2_stop_c0");
        step(0, 0, 0, 0, 5'b10110, "t2_stp_c1");
        step(0, 0, 0, 0, 5'b10110, "t2_stp_c2");
        step(0, 0, 0, 0, 5'b00110, "t2_stp_c3");
        step(0, 0, 0, 0, 5'b01110, "t2_stp_c4");
        step(0, 0, 0, 0, 5'b00010, "t2_idle");

        // Test 3: N=4 running, change to 3 at cnt=1
        step(0, 0, 1, 4, 5'b00010, "t3_cfg4");
        step(1, 0, 0, 0, 5'b00010, "t3_start");
        step(0, 0, 0, 0, 5'b10110, "t3_n4_c0");
        step(0, 0, 1, 3, 5'b10110, "t3_n4_c1_req");
        step(0, 0, 0, 0, 5'b00100, "t3_n4_c2_pend");
        step(0, 0, 0, 0, 5'b01100, "t3_n4_c3_pend");
        repeat (2) begin
            step(0, 0, 0, 0, 5'b10110, "t3_n3_c0");
            step(0, 0, 0, 0, 5'b10110, "t3_n3_c1");
            step(0, 0, 0, 0, 5'b01110, "t3_n3_c2");
        end

        // Test 5 (RUN): illegal ratios 0 and 1
        step(0, 0, 1, 0, 5'b10110, "t5r_c0_div0");
        step(0, 0, 1, 1, 5'b10111, "t5r_c1_err");
        step(0, 0, 0, 0, 5'b01111, "t5r_c2_err");
        step(0, 0, 0, 0, 5'b10110, "t5r_c0");

        // Test 4: stop at cnt=0, then stop cancelled by start
        step(0, 0, 0, 0, 5'b10110, "t4_c1");
        step(0, 0, 0, 0, 5'b01110, "t4_c2");
        step(0, 1, 0, 0, 5'b10110, "t4_stop_c0");
        step(0, 0, 0, 0, 5'b10110, "t4_stp_c1");
        step(0, 0, 0, 0, 5'b01110, "t4_stp_c2");
        step(0, 0, 0, 0, 5'b00010, "t4_idle");
        step(1, 0, 0, 0, 5'b00010, "t4_restart");
        step(0, 1, 0, 0, 5'b10110, "t4_stop2_c0");
        step(1, 0, 0, 0, 5'b10110, "t4_cancel_c1");
        step(0, 0, 0, 0, 5'b01110, "t4_run_c2");
        step(0, 0, 0, 0, 5'b10110, "t4_run_c0");
        step(0, 0, 0, 0, 5'b10110, "t4_run_c1");
        step(0, 1, 0, 0, 5'b01110, "t4_stop_at_tick");
        step(0, 0, 0, 0, 5'b10110, "t4_stp3_c0");
        step(0, 0, 0, 0, 5'b10110, "t4_stp3_c1");
        step(0, 0, 0, 0, 5'b01110, "t4_stp3_c2");
        step(0, 0, 0, 0, 5'b00010, "t4_idle2");

        // Test 5 (IDLE): illegal ratios 1 and 0, ratio stays 3
        step(0, 0, 1, 1, 5'b00010, "t5i_div1");
        step(0, 0, 1, 0, 5'b00011, "t5i_err1");
        step(0, 0, 0, 0, 5'b00011, "t5i_err0");
        step(1, 0, 0, 0, 5'b00010, "t5i_start");
        step(0, 0, 0, 0, 5'b10110, "t5i_c0");
        step(0, 0, 0, 0, 5'b10110, "t5i_c1");
        step(0, 0, 0, 0, 5'b01110, "t5i_c2");

        // Test 6: N=7, reset at cnt=4
        step(0, 0, 1, 7, 5'b10110, "t6_n3_c0_req");
        step(0, 0, 0, 0, 5'b10100, "t6_n3_c1_pend");
        step(0, 0, 0, 0, 5'b01100, "t6_n3_c2_pend");
        step(0, 0, 0, 0, 5'b10110, "t6_n7_c0");
        step(0, 0, 0, 0, 5'b10110, "t6_n7_c1");
        step(0, 0, 0, 0, 5'b10110, "t6_n7_c2");
        step(0, 0, 0, 0, 5'b10110, "t6_n7_c3");
        step(0, 0, 0, 0, 5'b00110, "t6_n7_c4");
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 0, 5'b00010, "t6_in_reset");
        rst = 1'b1;
        step(1, 0, 0, 0, 5'b00010, "t6_idle_start");
        step(0, 0, 0, 0, 5'b10110, "t6_def_hi");
        step(0, 0, 0, 0, 5'b01110, "t6_def_lo");
        step(0, 0, 0, 0, 5'b10110, "t6_def_hi2");
        step(0, 0, 0, 0, 5'b01110, "t6_def_lo2");

        // Drain scoreboard, bounded
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
